// File: rtl/vs_pipeline_reg.sv
// rtl/vs_pipeline_reg.sv - elastic valid/ready register chain, DEPTH stages of WIDTH bits, bubble-collapsing
// Optional occupancy output enabled by VS_PIPELINE_REG_OCCUPANCY_EN.
module vs_pipeline_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef VS_PIPELINE_REG_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [WIDTH-1:0] src    [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] up;
    logic             accept;

    // Advance chain walks back from the consumer; carry is "stage i can load".
    always_comb begin
        logic carry;
        carry = out_ready;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = valid_q[i] & carry;
            carry  = ~valid_q[i] | adv[i];
        end
        in_ready = carry & ~flush;
        accept   = in_valid & in_ready;
        up[0]    = accept;
        src[0]   = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up[i]  = adv[i-1];
            src[i] = data_q[i-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (up[i]) begin
                    valid_d[i] = 1'b1;
                    data_d[i]  = src[i];
                end else if (adv[i]) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

`ifdef VS_PIPELINE_REG_OCCUPANCY_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] occ_q, occ_d;

    // An output transfer during flush still leaves the count at zero.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !adv[DEPTH-1]) begin
            occ_d = occ_q + CW'(1);
        end else if (adv[DEPTH-1] && !accept) begin
            occ_d = occ_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_vs_pipeline_reg.sv
// tb/tb_vs_pipeline_reg.sv - directed self-checking bench for vs_pipeline_reg (DEPTH=3 and DEPTH=1)
module tb_vs_pipeline_reg;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;

    logic       d1_flush = 1'b0;
    logic       d1_in_valid = 1'b0;
    logic [7:0] d1_in_data = 8'h00;
    logic       d1_in_ready;
    logic       d1_out_valid;
    logic [7:0] d1_out_data;
    logic       d1_out_ready = 1'b0;

`ifdef VS_PIPELINE_REG_OCCUPANCY_EN
    logic [1:0] occupancy;
    logic       d1_occupancy;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    vs_pipeline_reg #(.WIDTH(8), .DEPTH(3)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef VS_PIPELINE_REG_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    vs_pipeline_reg #(.WIDTH(8), .DEPTH(1)) u_dut_d1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (d1_flush),
        .in_valid  (d1_in_valid),
        .in_data   (d1_in_data),
        .in_ready  (d1_in_ready),
        .out_valid (d1_out_valid),
        .out_data  (d1_out_data),
        .out_ready (d1_out_ready)
`ifdef VS_PIPELINE_REG_OCCUPANCY_EN
        ,
        .occupancy (d1_occupancy)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_occ(input string tag, input int exp);
`ifdef VS_PIPELINE_REG_OCCUPANCY_EN
        check_eq(tag, 32'(occupancy), 32'(exp));
`else
        if (exp < 0) $display("[TB] bad occupancy argument %s", tag);
`endif
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (v) check_eq({tag, "_data"}, 32'(out_data), 32'(d));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset values, asynchronous
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_occ("rst_occ", 0);
        #11;
        reset_n = 1'b1;
        step();

        // Streaming, latency 3
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        #1;
        check_eq("str_in_ready0", 32'(in_ready), 32'd1);
        step();
        check_out("str_e1", 1'b0, 8'h00);
        in_data = 8'h22;
        step();
        check_out("str_e2", 1'b0, 8'h00);
        check_eq("str_in_ready2", 32'(in_ready), 32'd1);
        in_data = 8'h33;
        step();
        check_out("str_w0", 1'b1, 8'h11);
        in_valid = 1'b0;
        step();
        check_out("str_w1", 1'b1, 8'h22);
        step();
        check_out("str_w2", 1'b1, 8'h33);
        step();
        check_out("str_empty", 1'b0, 8'h00);
        check_eq("str_hold_data", 32'(out_data), 32'h33);

        // Back-pressure fill then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        step();
        check_occ("bp_occ1", 1);
        in_data = 8'h02;
        step();
        check_occ("bp_occ2", 2);
        in_data = 8'h03;
        step();
        check_occ("bp_occ3", 3);
        check_out("bp_full", 1'b1, 8'h01);
        in_data = 8'h04;
        #1;
        check_eq("bp_in_ready_full", 32'(in_ready), 32'd0);
        step();
        check_out("bp_stall", 1'b1, 8'h01);
        check_eq("bp_in_ready_stall", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_drain", 32'(in_ready), 32'd1);
        step();
        check_out("bp_o2", 1'b1, 8'h02);
        check_occ("bp_occ_hover", 3);
        in_data = 8'h05;
        step();
        check_out("bp_o3", 1'b1, 8'h03);
        in_valid = 1'b0;
        step();
        check_out("bp_o4", 1'b1, 8'h04);
        step();
        check_out("bp_o5", 1'b1, 8'h05);
        step();
        check_out("bp_done", 1'b0, 8'h00);
        check_occ("bp_occ0", 0);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA0;
        step();
        in_valid = 1'b0;
        step();
        step();
        check_out("bub_a0", 1'b1, 8'hA0);
        in_valid = 1'b1;
        in_data  = 8'hA1;
        #1;
        check_eq("bub_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step();
        check_eq("bub_in_ready2", 32'(in_ready), 32'd1);
        check_occ("bub_occ", 2);
        out_ready = 1'b1;
        #1;
        check_out("bub_out0", 1'b1, 8'hA0);
        step();
        check_out("bub_out1", 1'b1, 8'hA1);
        step();
        check_out("bub_empty", 1'b0, 8'h00);

        // Full with simultaneous accept and drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h10;
        step();
        in_data = 8'h20;
        step();
        in_data = 8'h30;
        step();
        check_out("fs_full", 1'b1, 8'h10);
        in_data   = 8'h40;
        out_ready = 1'b1;
        #1;
        check_eq("fs_in_ready", 32'(in_ready), 32'd1);
        step();
        check_out("fs_next", 1'b1, 8'h20);
        check_occ("fs_occ", 3);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("fs_still_full", 32'(in_ready), 32'd0);

        // Flush with a pending offer
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        check_eq("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_out("fl_empty", 1'b0, 8'h00);
        check_eq("fl_data_hold", 32'(out_data), 32'h20);
        check_occ("fl_occ", 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("fl_no_55", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h66;
        step();
        in_data = 8'h77;
        step();
        in_valid = 1'b0;
        step();
        check_out("ar_before", 1'b1, 8'h66);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_out_valid", 32'(out_valid), 32'd0);
        check_eq("ar_out_data", 32'(out_data), 32'd0);
        check_eq("ar_in_ready", 32'(in_ready), 32'd1);
        check_occ("ar_occ", 0);
        #2;
        reset_n = 1'b1;
        step();
        check_eq("ar_after", 32'(out_valid), 32'd0);

        // DEPTH=1 streaming
        d1_out_ready = 1'b1;
        d1_in_valid  = 1'b1;
        d1_in_data   = 8'h7E;
        step();
        check_eq("d1_v0", 32'(d1_out_valid), 32'd1);
        check_eq("d1_d0", 32'(d1_out_data), 32'h7E);
        d1_in_data = 8'h7F;
        #1;
        check_eq("d1_in_ready", 32'(d1_in_ready), 32'd1);
        step();
        check_eq("d1_v1", 32'(d1_out_valid), 32'd1);
        check_eq("d1_d1", 32'(d1_out_data), 32'h7F);
        d1_in_valid = 1'b0;
        step();
        check_eq("d1_empty", 32'(d1_out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
